sprite_renderer: RTL and testbench

- Pixel-pipeline stage directly upstream of the 4-sprite 16x16 4-bit sprite ROM (1024 x 4, 10-bit address, registered read with 1-cycle latency).
- From the video timing counters and a per-frame sprite position, it generates the ROM address, absorbs the ROM read latency, and produces a time-aligned sprite colour and a coverage flag for the downstream colour mixer.
- Sprite position, index, flip and enable are latched once per frame so there is no tearing. An optional frame-based animation counter steps the sprite index.

---
 rtl/sprite_renderer_if.sv | 29 ++
 rtl/sprite_renderer.sv | 90 +++++++++
 tb/tb_sprite_renderer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_renderer_if.sv
// Pixel/config bundle between video timing, the sprite renderer and the sprite ROM.
interface sprite_renderer_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       active;
  logic       frame_start;
  logic [9:0] pos_x_in;
  logic [9:0] pos_y_in;
  logic [1:0] idx_in;
  logic       hflip_in;
  logic       en_in;
  logic       anim_en_in;
  logic [3:0] rom_pixel;
  logic [9:0] rom_add;
  logic       sprite_on;
  logic [3:0] color;

  modport master (
    output hcount, vcount, active, frame_start,
    output pos_x_in, pos_y_in, idx_in, hflip_in, en_in, anim_en_in, rom_pixel,
    input  rom_add, sprite_on, color
  );

  modport slave (
    input  hcount, vcount, active, frame_start,
    input  pos_x_in, pos_y_in, idx_in, hflip_in, en_in, anim_en_in, rom_pixel,
    output rom_add, sprite_on, color
  );
endinterface

// File: rtl/sprite_renderer.sv
// Sprite hit test, ROM addressing and 3-cycle aligned colour/coverage output
// with per-frame shadowed position/index and frame-based animation.
module sprite_renderer #(
  parameter int         SPR_W    = 16,
  parameter int         SPR_H    = 16,
  parameter logic [3:0] TRANSP   = 4'h0,
  parameter int         ANIM_DIV = 8
) (
  input  logic              clk,
  input  logic              rstn,
  sprite_renderer_if.slave  bus
);

  logic [9:0] pos_x_q, pos_y_q;
  logic [1:0] idx_q;
  logic       hflip_q, en_q, anim_en_q;
  logic [7:0] anim_cnt_q, anim_cnt_d;
  logic [1:0] anim_step_q, anim_step_d;

  logic [10:0] dx, dy;
  logic        hit0;
  logic [1:0]  eff_idx;
  logic [3:0]  col;
  logic [9:0]  rom_add_q, rom_add_d;
  logic [1:0]  hit_pipe_q;  // [0] aligned with rom_add, [1] with rom_pixel
  logic        sprite_on_q, sprite_on_d;
  logic [3:0]  color_q;

  always_comb begin
    // MSB of the 11-bit difference is the borrow: pixel left of / above the sprite
    dx      = {1'b0, bus.hcount} - {1'b0, pos_x_q};
    dy      = {1'b0, bus.vcount} - {1'b0, pos_y_q};
    hit0    = bus.active & en_q & ~dx[10] & ~dy[10] &
              (dx[9:0] < 10'(SPR_W)) & (dy[9:0] < 10'(SPR_H));
    eff_idx = idx_q + anim_step_q;
    col     = hflip_q ? ~dx[3:0] : dx[3:0];
    rom_add_d = hit0 ? {eff_idx, dy[3:0], col} : rom_add_q;

    anim_cnt_d  = anim_cnt_q;
    anim_step_d = anim_step_q;
    if (!anim_en_q) begin
      anim_cnt_d  = '0;
      anim_step_d = '0;
    end else if (anim_cnt_q == 8'(ANIM_DIV - 1)) begin
      anim_cnt_d  = '0;
      anim_step_d = anim_step_q + 2'd1;
    end else begin
      anim_cnt_d  = anim_cnt_q + 8'd1;
    end

    sprite_on_d = hit_pipe_q[1] & (bus.rom_pixel != TRANSP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      idx_q       <= '0;
      hflip_q     <= 1'b0;
      en_q        <= 1'b0;
      anim_en_q   <= 1'b0;
      anim_cnt_q  <= '0;
      anim_step_q <= '0;
      rom_add_q   <= '0;
      hit_pipe_q  <= '0;
      sprite_on_q <= 1'b0;
      color_q     <= TRANSP;
    end else begin
      if (bus.frame_start) begin
        pos_x_q     <= bus.pos_x_in;
        pos_y_q     <= bus.pos_y_in;
        idx_q       <= bus.idx_in;
        hflip_q     <= bus.hflip_in;
        en_q        <= bus.en_in;
        anim_en_q   <= bus.anim_en_in;
        anim_cnt_q  <= anim_cnt_d;
        anim_step_q <= anim_step_d;
      end
      rom_add_q   <= rom_add_d;
      hit_pipe_q  <= {hit_pipe_q[0], hit0};
      sprite_on_q <= sprite_on_d;
      color_q     <= sprite_on_d ? bus.rom_pixel : TRANSP;
    end
  end

  assign bus.rom_add   = rom_add_q;
  assign bus.sprite_on = sprite_on_q;
  assign bus.color     = color_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed + randomized bench for sprite_renderer against a pixel-level reference model.
module tb_sprite_renderer;
  localparam int ANIM_DIV = 2;

  logic clk = 1'b0;
  logic rstn;
  sprite_renderer_if bus();

  sprite_renderer #(.ANIM_DIV(ANIM_DIV)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  // Sprite ROM: 1024 x 4, registered read
  logic [3:0] rom [1024];
  logic [3:0] rom_q = 4'h0;
  always @(posedge clk) rom_q <= rom[bus.rom_add];
  assign bus.rom_pixel = rom_q;

  int tests = 0;
  int fails = 0;

  // reference model state
  int sh_px, sh_py, sh_idx, sh_hf, sh_en, sh_an;
  int a_cnt, a_step;
  int exp_addr;
  int pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    sh_px = 0; sh_py = 0; sh_idx = 0; sh_hf = 0; sh_en = 0; sh_an = 0;
    a_cnt = 0; a_step = 0; exp_addr = 0;
    pend.delete();
    pend.push_back(0);
    pend.push_back(0);
  endtask

  task automatic cfg(input int px, input int py, input int idx, input int hf, input int en, input int an);
    bus.pos_x_in   = 10'(px);
    bus.pos_y_in   = 10'(py);
    bus.idx_in     = 2'(idx);
    bus.hflip_in   = hf[0];
    bus.en_in      = en[0];
    bus.anim_en_in = an[0];
  endtask

  // One pixel clock: model predicts, DUT clocks, outputs checked 1 time unit later
  task automatic cyc(input int hc, input int vc, input bit act, input bit fs);
    int dx, dy, a, e;
    bit hit;
    logic [3:0] c;
    bus.hcount = 10'(hc);
    bus.vcount = 10'(vc);
    bus.active = act;
    bus.frame_start = fs;
    dx = hc - sh_px;
    dy = vc - sh_py;
    hit = act && (sh_en != 0) && dx >= 0 && dx < 16 && dy >= 0 && dy < 16;
    c = 4'h0;
    if (hit) begin
      a = (((sh_idx + a_step) % 4) * 256) + dy * 16 + ((sh_hf != 0) ? 15 - dx : dx);
      exp_addr = a;
      c = rom[a];
    end
    pend.push_back((hit && c != 4'h0) ? 16 + int'(c) : 0);
    @(posedge clk);
    if (fs) begin
      if (sh_an != 0) begin
        if (a_cnt == ANIM_DIV - 1) begin a_cnt = 0; a_step = (a_step + 1) % 4; end
        else a_cnt++;
      end else begin
        a_cnt = 0; a_step = 0;
      end
      sh_px = int'(bus.pos_x_in); sh_py = int'(bus.pos_y_in); sh_idx = int'(bus.idx_in);
      sh_hf = int'(bus.hflip_in); sh_en = int'(bus.en_in); sh_an = int'(bus.anim_en_in);
    end
    #1;
    e = pend.pop_front();
    chk("rom_add", 32'(bus.rom_add), 32'(exp_addr));
    chk("sprite_on", 32'(bus.sprite_on), 32'(e[4]));
    chk("color", 32'(bus.color), 32'(e[3:0]));
  endtask

  task automatic idle();
    cyc(0, 0, 1'b0, 1'b0);
  endtask

  task automatic frame();
    cyc(0, 0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_sprite_on", 32'(bus.sprite_on), 32'd0);
    chk("rst_color", 32'(bus.color), 32'd0);
    chk("rst_rom_add", 32'(bus.rom_add), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  int seq[10] = '{3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
  bit seen;

  initial begin
    rstn = 1'b1;
    bus.hcount = '0; bus.vcount = '0; bus.active = 1'b0; bus.frame_start = 1'b0;
    cfg(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[10'h100] = 4'h5;
    rom[10'h12F] = 4'h0;
    rom[10'h101] = 4'h7;
    #2;
    do_reset();

    // basic hit at the sprite origin
    cfg(100, 50, 1, 0, 1, 0);
    frame();
    cyc(100, 50, 1'b1, 1'b0);
    chk("tp_addr_origin", 32'(bus.rom_add), 32'h100);
    idle(); idle();
    chk("tp_on_origin", 32'(bus.sprite_on), 32'd1);
    chk("tp_col_origin", 32'(bus.color), 32'd5);

    // just outside left and right edges, then bottom-right corner
    cyc(99, 50, 1'b1, 1'b0);
    cyc(116, 50, 1'b1, 1'b0);
    idle();
    chk("tp_left_off", 32'(bus.sprite_on), 32'd0);
    idle();
    chk("tp_right_off", 32'(bus.sprite_on), 32'd0);
    chk("tp_right_col", 32'(bus.color), 32'd0);
    cyc(115, 65, 1'b1, 1'b0);
    chk("tp_addr_corner", 32'(bus.rom_add), 32'h1FF);

    // horizontal flip onto a transparent texel
    cfg(100, 50, 1, 1, 1, 0);
    frame();
    cyc(100, 52, 1'b1, 1'b0);
    chk("tp_addr_hflip", 32'(bus.rom_add), 32'h12F);
    idle(); idle();
    chk("tp_transp_on", 32'(bus.sprite_on), 32'd0);
    chk("tp_transp_col", 32'(bus.color), 32'd0);

    // clipping at the screen edge, no wrap to x = 0
    cfg(1020, 470, 1, 0, 1, 0);
    frame();
    cyc(1023, 479, 1'b1, 1'b0);
    chk("tp_addr_clip", 32'(bus.rom_add), 32'h193);
    cyc(5, 470, 1'b1, 1'b0);
    chk("tp_addr_nowrap_hold", 32'(bus.rom_add), 32'h193);
    idle(); idle();
    chk("tp_nowrap_on", 32'(bus.sprite_on), 32'd0);

    // animation: index steps every ANIM_DIV frames
    cfg(100, 50, 3, 0, 1, 1);
    frame();
    for (int k = 0; k < 10; k++) begin
      cyc(100, 50, 1'b1, 1'b0);
      chk($sformatf("anim_idx_%0d", k), 32'(bus.rom_add[9:8]), 32'(seq[k]));
      frame();
    end

    // disabled sprite never shows
    cfg(100, 50, 1, 0, 0, 0);
    frame();
    idle(); idle();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc($urandom_range(96, 120), $urandom_range(46, 70), 1'b1, 1'b0);
      seen |= bus.sprite_on;
    end
    chk("en0_never_on", 32'(seen), 32'd0);

    // reset mid-line while the sprite is visible
    cfg(100, 50, 1, 0, 1, 0);
    frame(); frame();
    cyc(101, 50, 1'b1, 1'b0);
    idle(); idle();
    chk("pre_rst_on", 32'(bus.sprite_on), 32'd1);
    chk("pre_rst_col", 32'(bus.color), 32'd7);
    do_reset();
    cyc(101, 50, 1'b1, 1'b0);
    idle(); idle();
    chk("post_rst_en0", 32'(bus.sprite_on), 32'd0);
    frame();
    cyc(101, 50, 1'b1, 1'b0);
    idle(); idle();
    chk("post_rst_on", 32'(bus.sprite_on), 32'd1);
    chk("post_rst_col", 32'(bus.color), 32'd7);

    // randomized frames; the frame_start cycle also carries a live pixel
    for (int f = 0; f < 40; f++) begin
      cfg($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 3),
          $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1));
      cyc($urandom_range(0, 63), $urandom_range(0, 63), 1'b1, 1'b1);
      for (int i = 0; i < 40; i++)
        cyc($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 4) != 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
